// File: rtl/bch_gf_pkg.sv
// Shared GF(2^5) definitions for the BCH(31, T=3) decoder stages.
package bch_gf_pkg;

    localparam int unsigned N = 31;
    localparam int unsigned M = 5;
    localparam int unsigned T = 3;

    // p(x) = x^5 + x^2 + 1
    localparam logic [M:0] PRIM_POLY = 6'b100101;

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    // Multiply by alpha: shift left, reduce by p(x) on overflow.
    function automatic logic [M-1:0] gf_mul_alpha(input logic [M-1:0] a);
        return {a[M-2:0], 1'b0} ^ (a[M-1] ? PRIM_POLY[M-1:0] : '0);
    endfunction

    // alpha^e (exponent taken mod N).
    function automatic logic [M-1:0] gf_exp(input int unsigned e);
        logic [M-1:0] v;
        v = 1;
        for (int unsigned i = 0; i < (e % N); i++) begin
            v = gf_mul_alpha(v);
        end
        return v;
    endfunction

    // log_alpha(a); returns 0 for a == 0 (undefined, caller must guard).
    function automatic logic [M-1:0] gf_log(input logic [M-1:0] a);
        logic [M-1:0] v;
        logic [M-1:0] lg;
        v  = 1;
        lg = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (v == a) begin
                lg = i[M-1:0];
            end
            v = gf_mul_alpha(v);
        end
        return lg;
    endfunction

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        if (a == '0 || b == '0) begin
            return '0;
        end
        return gf_exp(int'(gf_log(a)) + int'(gf_log(b)));
    endfunction

    function automatic logic [M-1:0] gf_inv(input logic [M-1:0] a);
        if (a == '0) begin
            return '0;
        end
        return gf_exp(N - int'(gf_log(a)));
    endfunction

endpackage

// File: rtl/bch_gf_const_mul.sv
// Combinational multiply by the constant alpha^K in GF(2^5).
module bch_gf_const_mul
    import bch_gf_pkg::*;
#(
    parameter int unsigned K = 1
) (
    input  logic [M-1:0] din,
    output logic [M-1:0] dout
);

    // Unrolled chain of K multiply-by-alpha steps.
    always_comb begin
        dout = din;
        for (int unsigned j = 0; j < K; j++) begin
            dout = gf_mul_alpha(dout);
        end
    end

endmodule

// File: rtl/bch_chien_search.sv
// Chien search: evaluates sigma(alpha^i) for i = 0..N-1 and streams error positions.
module bch_chien_search
    import bch_gf_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [M-1:0] sigma0,
    input  logic [M-1:0] sigma1,
    input  logic [M-1:0] sigma2,
    input  logic [M-1:0] sigma3,
    input  logic [3:0]   L,
    output logic         busy,
    output logic         err_valid,
    output logic [M-1:0] err_pos,
    output logic         done,
    output logic [3:0]   err_count,
    output logic         fail
);

    state_t       state_q, state_d;
    logic [M-1:0] r0_q, r1_q, r2_q, r3_q;
    logic [M-1:0] r0_d, r1_d, r2_d, r3_d;
    logic [M-1:0] r1_next, r2_next, r3_next;
    logic [M-1:0] idx_q, idx_d;
    logic [3:0]   l_q, l_d;
    logic         err_valid_q, err_valid_d;
    logic [M-1:0] err_pos_q, err_pos_d;
    logic         done_q, done_d;
    logic [3:0]   err_count_q, err_count_d;
    logic         fail_q, fail_d;

    logic [M-1:0] eval;
    logic [3:0]   cnt_inc;
    logic [3:0]   cnt_final;

    bch_gf_const_mul #(.K(1)) u_mul1 (.din(r1_q), .dout(r1_next));
    bch_gf_const_mul #(.K(2)) u_mul2 (.din(r2_q), .dout(r2_next));
    bch_gf_const_mul #(.K(3)) u_mul3 (.din(r3_q), .dout(r3_next));

    // Next-state: start acceptance, early exits, per-index root detection.
    always_comb begin
        state_d     = state_q;
        r0_d        = r0_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        idx_d       = idx_q;
        l_d         = l_q;
        err_valid_d = 1'b0;
        err_pos_d   = err_pos_q;
        done_d      = 1'b0;
        err_count_d = err_count_q;
        fail_d      = fail_q;

        eval      = r0_q ^ r1_q ^ r2_q ^ r3_q;
        cnt_inc   = (err_count_q == 4'hF) ? err_count_q : err_count_q + 4'd1;
        cnt_final = (eval == '0) ? cnt_inc : err_count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_count_d = '0;
                    fail_d      = 1'b0;
                    idx_d       = '0;
                    l_d         = L;
                    if (L == 4'd0) begin
                        done_d = 1'b1;
                    end else if (L > 4'(T)) begin
                        done_d = 1'b1;
                        fail_d = 1'b1;
                    end else begin
                        r0_d    = sigma0;
                        r1_d    = sigma1;
                        r2_d    = sigma2;
                        r3_d    = sigma3;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                r1_d  = r1_next;
                r2_d  = r2_next;
                r3_d  = r3_next;
                idx_d = idx_q + 1'b1;
                if (eval == '0) begin
                    err_valid_d = 1'b1;
                    // Root at alpha^i locates the error at position -i mod N.
                    err_pos_d   = (idx_q == '0) ? '0 : M'(N) - idx_q;
                    err_count_d = cnt_inc;
                end
                if (idx_q == M'(N - 1)) begin
                    done_d  = 1'b1;
                    fail_d  = (cnt_final != l_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            r0_q        <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            idx_q       <= '0;
            l_q         <= '0;
            err_valid_q <= 1'b0;
            err_pos_q   <= '0;
            done_q      <= 1'b0;
            err_count_q <= '0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r0_q        <= r0_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            idx_q       <= idx_d;
            l_q         <= l_d;
            err_valid_q <= err_valid_d;
            err_pos_q   <= err_pos_d;
            done_q      <= done_d;
            err_count_q <= err_count_d;
            fail_q      <= fail_d;
        end
    end

    assign busy      = (state_q == SCAN);
    assign err_valid = err_valid_q;
    assign err_pos   = err_pos_q;
    assign done      = done_q;
    assign err_count = err_count_q;
    assign fail      = fail_q;

endmodule

// File: tb/tb_bch_chien_search.sv
// Directed self-checking bench for bch_chien_search.
module tb_bch_chien_search;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] sigma0, sigma1, sigma2, sigma3;
    logic [3:0] L;
    logic       busy, err_valid, done, fail;
    logic [4:0] err_pos;
    logic [3:0] err_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Results captured by run_search
    int   found_n;
    int   found_i[4];
    int   found_pos[4];
    int   done_k;
    logic busy_bad;

    bch_chien_search dut (
        .clk(clk), .reset(reset), .start(start),
        .sigma0(sigma0), .sigma1(sigma1), .sigma2(sigma2), .sigma3(sigma3),
        .L(L), .busy(busy), .err_valid(err_valid), .err_pos(err_pos),
        .done(done), .err_count(err_count), .fail(fail)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1. Sample k is taken in the cycle after edge Ek (E0 = accept).
    task automatic run_search(input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                              input logic [4:0] s3, input logic [3:0] l, input int inject_at);
        sigma0 = s0; sigma1 = s1; sigma2 = s2; sigma3 = s3; L = l; start = 1'b1;
        found_n = 0; done_k = -1; busy_bad = 1'b0;
        for (int j = 0; j < 4; j++) begin
            found_i[j] = -1; found_pos[j] = -1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (err_valid) begin
                if (found_n < 4) begin
                    found_i[found_n]   = k - 1;
                    found_pos[found_n] = int'(err_pos);
                end
                found_n++;
            end
            if (done) begin
                done_k = k;
                if (busy) busy_bad = 1'b1;
                break;
            end else if (!busy) begin
                busy_bad = 1'b1;
            end
            if (k == inject_at) begin
                start = 1'b1; sigma1 = 5'b11001; sigma2 = 5'b11100; L = 4'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; L = '0;
        sigma0 = '0; sigma1 = '0; sigma2 = '0; sigma3 = '0;
        idle(3);
        n_checks++;
        if ({busy, err_valid, done, fail} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got busy/ev/done/fail=%b, expected 0000", {busy, err_valid, done, fail});
        end
        n_checks++;
        if ({err_pos, err_count} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_values: got err_pos=%0d err_count=%0d, expected 0 0", err_pos, err_count);
        end
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_no_error;
        run_search(5'd1, 5'd0, 5'd0, 5'd0, 4'd0, -1);
        n_checks++;
        if (done_k !== 0) begin
            n_fail++;
            $display("FAIL no_err_done_k: got %0d, expected 0", done_k);
        end
        n_checks++;
        if (found_n !== 0 || err_count !== 4'd0 || fail !== 1'b0) begin
            n_fail++;
            $display("FAIL no_err_result: got found=%0d count=%0d fail=%b, expected 0 0 0", found_n, err_count, fail);
        end
        idle(1);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL no_err_done_pulse: got done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_single;
        idle(2);
        run_search(5'd1, 5'b00101, 5'd0, 5'd0, 4'd1, -1);
        n_checks++;
        if (done_k !== 31 || busy_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL single_timing: got done_k=%0d busy_bad=%b, expected 31 0", done_k, busy_bad);
        end
        n_checks++;
        if (found_n !== 1 || found_i[0] !== 26 || found_pos[0] !== 5) begin
            n_fail++;
            $display("FAIL single_root: got n=%0d i=%0d pos=%0d, expected 1 26 5", found_n, found_i[0], found_pos[0]);
        end
        n_checks++;
        if (err_count !== 4'd1 || fail !== 1'b0) begin
            n_fail++;
            $display("FAIL single_status: got count=%0d fail=%b, expected 1 0", err_count, fail);
        end
    endtask

    task automatic test_wrap;
        idle(2);
        run_search(5'd1, 5'b00001, 5'd0, 5'd0, 4'd1, -1);
        n_checks++;
        if (found_n !== 1 || found_i[0] !== 0 || found_pos[0] !== 0) begin
            n_fail++;
            $display("FAIL wrap_root: got n=%0d i=%0d pos=%0d, expected 1 0 0", found_n, found_i[0], found_pos[0]);
        end
        n_checks++;
        if (done_k !== 31 || fail !== 1'b0 || err_count !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_status: got done_k=%0d fail=%b count=%0d, expected 31 0 1", done_k, fail, err_count);
        end
    endtask

    task automatic check_two(input string name);
        n_checks++;
        if (done_k !== 31 || found_n !== 2) begin
            n_fail++;
            $display("FAIL %s_count: got done_k=%0d n=%0d, expected 31 2", name, done_k, found_n);
        end
        n_checks++;
        if (found_i[0] !== 21 || found_pos[0] !== 10 || found_i[1] !== 28 || found_pos[1] !== 3) begin
            n_fail++;
            $display("FAIL %s_roots: got (%0d,%0d) (%0d,%0d), expected (21,10) (28,3)", name,
                     found_i[0], found_pos[0], found_i[1], found_pos[1]);
        end
        n_checks++;
        if (err_count !== 4'd2 || fail !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_status: got count=%0d fail=%b, expected 2 0", name, err_count, fail);
        end
    endtask

    task automatic test_two;
        idle(2);
        run_search(5'd1, 5'b11001, 5'b11100, 5'd0, 4'd2, -1);
        check_two("two");
        idle(3);
        n_checks++;
        if (err_count !== 4'd2 || fail !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL two_hold: got count=%0d fail=%b done=%b, expected 2 0 0", err_count, fail, done);
        end
    endtask

    task automatic test_uncorrectable;
        idle(2);
        run_search(5'd1, 5'b00101, 5'd0, 5'd0, 4'd2, -1);
        n_checks++;
        if (done_k !== 31 || found_n !== 1 || err_count !== 4'd1 || fail !== 1'b1) begin
            n_fail++;
            $display("FAIL uncorr_deg: got done_k=%0d n=%0d count=%0d fail=%b, expected 31 1 1 1",
                     done_k, found_n, err_count, fail);
        end
        idle(2);
        run_search(5'd1, 5'd3, 5'd7, 5'd9, 4'd4, -1);
        n_checks++;
        if (done_k !== 0 || fail !== 1'b1 || err_count !== 4'd0 || found_n !== 0) begin
            n_fail++;
            $display("FAIL uncorr_l4: got done_k=%0d fail=%b count=%0d n=%0d, expected 0 1 0 0",
                     done_k, fail, err_count, found_n);
        end
    endtask

    task automatic test_start_mid_scan;
        idle(2);
        run_search(5'd1, 5'b00101, 5'd0, 5'd0, 4'd1, 10);
        n_checks++;
        if (done_k !== 31 || found_n !== 1 || found_pos[0] !== 5 || err_count !== 4'd1 || fail !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_start: got done_k=%0d n=%0d pos=%0d count=%0d fail=%b, expected 31 1 5 1 0",
                     done_k, found_n, found_pos[0], err_count, fail);
        end
    endtask

    task automatic test_back_to_back;
        idle(2);
        run_search(5'd1, 5'b00001, 5'd0, 5'd0, 4'd1, -1);
        n_checks++;
        if (done_k !== 31 || found_pos[0] !== 0) begin
            n_fail++;
            $display("FAIL b2b_first: got done_k=%0d pos=%0d, expected 31 0", done_k, found_pos[0]);
        end
        // Next start issued in the done cycle
        run_search(5'd1, 5'b00101, 5'd0, 5'd0, 4'd1, -1);
        n_checks++;
        if (done_k !== 31 || found_n !== 1 || found_i[0] !== 26 || found_pos[0] !== 5) begin
            n_fail++;
            $display("FAIL b2b_second: got done_k=%0d n=%0d i=%0d pos=%0d, expected 31 1 26 5",
                     done_k, found_n, found_i[0], found_pos[0]);
        end
    endtask

    task automatic test_reset_mid;
        logic seen_done;
        idle(2);
        sigma0 = 5'd1; sigma1 = 5'b00101; sigma2 = '0; sigma3 = '0; L = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle(10);
        reset = 1'b0;
        idle(1);
        n_checks++;
        if ({busy, err_valid, done, fail} !== 4'b0000 || err_pos !== 5'd0 || err_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy/ev/done/fail=%b pos=%0d count=%0d, expected 0000 0 0",
                     {busy, err_valid, done, fail}, err_pos, err_count);
        end
        reset = 1'b1;
        seen_done = 1'b0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got activity=%b after abort, expected 0", seen_done);
        end
        run_search(5'd1, 5'b11001, 5'b11100, 5'd0, 4'd2, -1);
        check_two("after_reset");
    endtask

    initial begin
        test_reset;
        test_no_error;
        test_single;
        test_wrap;
        test_two;
        test_uncorrectable;
        test_start_mid_scan;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
